fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/npc_sel.sv | 43 ++++
 rtl/fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch controller.
//   state_t        : fetch FSM states (BOOT, REQ, WAIT, HOLD)
//   EXC_VECTOR     : exception redirect destination
//   DEF_RESET_PC   : default first fetch address after reset
//   DEF_PC_STEP    : default sequential PC increment
//   word_align()   : clears bits [1:0] of a redirect target
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP  = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/npc_sel.sv
// -----------------------------------------------------------------------------
// npc_sel
// Combinational redirect priority and next-PC mux.
// Priority: exception, then jump, then branch, else sequential.
// Ports:
//   pc            in  : current fetch PC
//   exc           in  : exception redirect request (tied low when unused)
//   jump          in  : jump redirect request
//   jump_target   in  : jump destination
//   branch_taken  in  : branch redirect request
//   branch_target in  : branch destination
//   redir         out : any redirect requested this cycle
//   npc           out : selected next PC (aligned target, or pc+PC_STEP)
// -----------------------------------------------------------------------------
module npc_sel
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
   input  logic [31:0] pc,
   input  logic        exc,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        redir,
   output logic [31:0] npc
);

   always_comb begin
      redir = exc | jump | branch_taken;
      // 32-bit add wraps naturally modulo 2^32
      npc   = pc + PC_STEP;
      if (exc) begin
         npc = EXC_VECTOR;
      end else if (jump) begin
         npc = word_align(jump_target);
      end else if (branch_taken) begin
         npc = word_align(branch_target);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller: issues one-cycle memory requests, waits for
// the read data, and holds the fetched instruction until consumed. Redirects
// (exception/jump/branch) restart fetch at the new target; a request already
// in flight when a redirect arrives has its data discarded.
// Optional feature macro: FETCH_EXC_EN adds the exc_req input.
//
// Handshake: the consumer takes inst_o/pc_o in every cycle where
// inst_valid=1 and stall=0. Memory: inst_ce is a one-cycle request strobe
// with inst_addr; exactly one imem_rvalid answers it, 1 or more cycles later.
//
// Ports:
//   clk           in  : clock
//   RST           in  : asynchronous active-high reset
//   stall         in  : consumer not ready
//   branch_taken  in  : branch redirect request (one cycle)
//   branch_target in  : branch destination
//   jump          in  : jump redirect request (one cycle)
//   jump_target   in  : jump destination
//   exc_req       in  : exception redirect (only with FETCH_EXC_EN)
//   inst_ce       out : memory request strobe
//   inst_addr     out : memory request address
//   imem_rdata    in  : memory read data
//   imem_rvalid   in  : memory read data valid
//   pc_o          out : address of inst_o
//   inst_o        out : fetched instruction
//   inst_valid    out : inst_o/pc_o valid
//   fsm_state     out : current FSM state (debug)
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
`ifdef FETCH_EXC_EN
   input  logic        exc_req,
`endif
   output logic        inst_ce,
   output logic [31:0] inst_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid,
   output logic [1:0]  fsm_state
);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] tgt;
   logic        discard;

   logic        exc;
   logic        redir;
   logic [31:0] npc;
   logic        eff_discard;
   logic [31:0] eff_target;

`ifdef FETCH_EXC_EN
   assign exc = exc_req;
`else
   assign exc = 1'b0;
`endif

   npc_sel #(.PC_STEP(PC_STEP)) u_npc_sel (
      .pc            (pc),
      .exc           (exc),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .redir         (redir),
      .npc           (npc)
   );

   // A redirect arriving in the same cycle as the read data counts as
   // pending: the data is dropped and the newest target wins.
   assign eff_discard = discard | redir;
   assign eff_target  = redir ? npc : tgt;

   assign fsm_state = state;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state      <= BOOT;
         pc         <= RESET_PC;
         tgt        <= RESET_PC;
         discard    <= 1'b0;
         inst_ce    <= 1'b0;
         inst_addr  <= RESET_PC;
         inst_valid <= 1'b0;
         inst_o     <= 32'h0;
         pc_o       <= 32'h0;
      end else begin
         // request strobe is high only in the cycle spent in REQ
         inst_ce <= 1'b0;
         case (state)
            BOOT: begin
               // redirects and stray read data are ignored here
               state     <= REQ;
               inst_ce   <= 1'b1;
               inst_addr <= pc;
            end
            REQ: begin
               state <= WAIT;
               if (redir) begin
                  discard <= 1'b1;
                  tgt     <= npc;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (eff_discard) begin
                     pc        <= eff_target;
                     discard   <= 1'b0;
                     state     <= REQ;
                     inst_ce   <= 1'b1;
                     inst_addr <= eff_target;
                  end else begin
                     inst_o     <= imem_rdata;
                     pc_o       <= pc;
                     inst_valid <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (redir) begin
                  discard <= 1'b1;
                  tgt     <= npc;
               end
            end
            HOLD: begin
               // a redirect overrides stall; npc is the target or pc+PC_STEP
               if (redir || !stall) begin
                  inst_valid <= 1'b0;
                  pc         <= npc;
                  state      <= REQ;
                  inst_ce    <= 1'b1;
                  inst_addr  <= npc;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. A second instance with RESET_PC=FFFFFFFC
// covers the PC wrap. Expected request addresses and consumed instructions
// are queued as stimulus is applied and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
   import fetch_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        RST;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
`ifdef FETCH_EXC_EN
   logic        exc_req;
`endif
   logic        inst_ce;
   logic [31:0] inst_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid;
   logic [1:0]  fsm_state;

   // wrap instance signals
   logic        w_ce;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic        w_rvalid;
   logic [31:0] w_pc_o;
   logic [31:0] w_inst_o;
   logic        w_valid;
   logic [1:0]  w_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_cons;
   logic rate_on;
   logic [31:0] p;

   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_inst_q[$];
   logic [31:0] exp_w_q[$];
   logic [63:0] exp_winst_q[$];

   function automatic logic [31:0] dgen(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   // ---------------- DUTs ----------------
   fetch_ctrl dut (
      .clk           (clk),
      .RST           (RST),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
`ifdef FETCH_EXC_EN
      .exc_req       (exc_req),
`endif
      .inst_ce       (inst_ce),
      .inst_addr     (inst_addr),
      .imem_rdata    (imem_rdata),
      .imem_rvalid   (imem_rvalid),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .inst_valid    (inst_valid),
      .fsm_state     (fsm_state)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk           (clk),
      .RST           (RST),
      .stall         (1'b0),
      .branch_taken  (1'b0),
      .branch_target (32'h0),
      .jump          (1'b0),
      .jump_target   (32'h0),
`ifdef FETCH_EXC_EN
      .exc_req       (1'b0),
`endif
      .inst_ce       (w_ce),
      .inst_addr     (w_addr),
      .imem_rdata    (w_rdata),
      .imem_rvalid   (w_rvalid),
      .pc_o          (w_pc_o),
      .inst_o        (w_inst_o),
      .inst_valid    (w_valid),
      .fsm_state     (w_state)
   );

   // ---------------- memory models ----------------
   // latency selectable 1..3 via lat; inj_rv forces a stray response
   int          lat;
   logic        inj_rv;
   logic [2:0]  sr;
   logic [31:0] ap [3];

   always @(posedge clk or posedge RST) begin
      if (RST) begin
         sr <= 3'b000;
      end else begin
         sr    <= {sr[1:0], inst_ce};
         ap[2] <= ap[1];
         ap[1] <= ap[0];
         ap[0] <= inst_addr;
      end
   end
   assign imem_rvalid = inj_rv | sr[lat-1];
   assign imem_rdata  = inj_rv ? 32'hDEAD_BEEF : dgen(ap[lat-1]);

   logic        wsr;
   logic [31:0] wap;
   always @(posedge clk or posedge RST) begin
      if (RST) begin
         wsr <= 1'b0;
      end else begin
         wsr <= w_ce;
         wap <= w_addr;
      end
   end
   assign w_rvalid = wsr;
   assign w_rdata  = dgen(wap);

   always @(posedge clk) cyc++;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // scoreboard: compare DUT outputs against queued expectations
   always @(negedge clk) begin
      if (!RST) begin
         if (inst_ce) begin
            total++;
            assert (exp_addr_q.size() > 0) else begin
               bad++;
               $error("FAIL ce_unexpected observed=%h expected=no_request", inst_addr);
            end
            if (exp_addr_q.size() > 0) chk("ce_addr", inst_addr, exp_addr_q.pop_front());
         end
         if (inst_valid && !stall) begin
            total++;
            assert (exp_inst_q.size() > 0) else begin
               bad++;
               $error("FAIL inst_unexpected observed=%h expected=no_instruction", {pc_o, inst_o});
            end
            if (exp_inst_q.size() > 0) chk("inst_out", {pc_o, inst_o}, exp_inst_q.pop_front());
            if (rate_on && last_cons >= 0) chk("rate", cyc - last_cons, 3);
            last_cons = cyc;
         end
         if (w_ce && exp_w_q.size() > 0) chk("wrap_addr", w_addr, exp_w_q.pop_front());
         if (w_valid && exp_winst_q.size() > 0) chk("wrap_inst", {w_pc_o, w_inst_o}, exp_winst_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input state_t s);
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (fsm_state == s) return;
      end
      total++;
      bad++;
      $error("FAIL wait_state_timeout observed=%0d expected=%0d", fsm_state, s);
   endtask

   task automatic wait_valid_pc(input logic [31:0] a);
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (inst_valid && pc_o == a) return;
      end
      total++;
      bad++;
      $error("FAIL wait_valid_timeout observed=%h expected=%h", pc_o, a);
   endtask

   task automatic push_inst(input logic [31:0] a);
      exp_inst_q.push_back({a, dgen(a)});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      RST = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0;
`ifdef FETCH_EXC_EN
      exc_req = 1'b0;
`endif
      inj_rv = 1'b0; lat = 1; rate_on = 1'b0; last_cons = -1;
      repeat (3) cycle();

      // reset values
      chk("rst_ce", inst_ce, 0);
      chk("rst_addr", inst_addr, 32'h0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_state", fsm_state, BOOT);
      chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
      chk("wrap_rst_state", w_state, BOOT);

      // phase 1: sequential fetch at latency 1, stray rvalid during BOOT
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'h8);
      push_inst(32'h0);
      push_inst(32'h4);
      exp_w_q.push_back(32'hFFFF_FFFC);
      exp_w_q.push_back(32'h0000_0000);
      exp_winst_q.push_back({32'hFFFF_FFFC, dgen(32'hFFFF_FFFC)});
      exp_winst_q.push_back({32'h0000_0000, dgen(32'h0000_0000)});
      rate_on = 1'b1;
      RST = 1'b0;
      inj_rv = 1'b1;
      @(negedge clk);
      chk("boot_ce", inst_ce, 0);
      chk("boot_state", fsm_state, BOOT);
      cycle();
      inj_rv = 1'b0;
      chk("req_state", fsm_state, REQ);
      chk("req_ce", inst_ce, 1);
      wait_valid_pc(32'h8);
      stall = 1'b1;
      chk("hold8_inst", inst_o, dgen(32'h8));
      rate_on = 1'b0;
      cycle();
      RST = 1'b1;
      #1;
      chk("abort_valid", inst_valid, 0);
      chk("abort_ce", inst_ce, 0);
      chk("abort_state", fsm_state, BOOT);
      chk("abort_inst", inst_o, 32'h0);
      stall = 1'b0;
      chk("p1_addr_q_empty", exp_addr_q.size(), 0);
      chk("p1_inst_q_empty", exp_inst_q.size(), 0);
      repeat (2) cycle();

      // phase 2: stall at pc 4, jump in WAIT, jump+branch in HOLD
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'h8);
      push_inst(32'h0);
      push_inst(32'h4);
      RST = 1'b0;
      wait_valid_pc(32'h4);
      stall = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", inst_valid, 1);
         chk("stall_pc", pc_o, 32'h4);
         chk("stall_inst", inst_o, dgen(32'h4));
         chk("stall_ce", inst_ce, 0);
      end
      cycle();
      stall = 1'b0;
      wait_state(WAIT);
      jump = 1'b1;
      jump_target = 32'h0000_0043;
      exp_addr_q.push_back(32'h0000_0040);
      cycle();
      jump = 1'b0;
      chk("drop_valid", inst_valid, 0);
      push_inst(32'h40);
      wait_valid_pc(32'h40);
      branch_taken = 1'b1; branch_target = 32'h100;
      jump = 1'b1; jump_target = 32'h200;
      exp_addr_q.push_back(32'h200);
      cycle();
      branch_taken = 1'b0; jump = 1'b0;
      chk("hold_redir_valid", inst_valid, 0);
      wait_valid_pc(32'h200);
      stall = 1'b1;
      chk("hold200_inst", inst_o, dgen(32'h200));
      cycle();
      RST = 1'b1;
      stall = 1'b0;
      chk("p2_addr_q_empty", exp_addr_q.size(), 0);
      chk("p2_inst_q_empty", exp_inst_q.size(), 0);

      // phase 3: latency 3, discard flag, target overwrite, redirect in REQ
      lat = 3;
      repeat (4) cycle();
      exp_addr_q.push_back(32'h0);
      RST = 1'b0;
      wait_state(WAIT);
      branch_taken = 1'b1; branch_target = 32'h301;
      cycle();
      branch_taken = 1'b0;
      jump = 1'b1; jump_target = 32'h502;
      exp_addr_q.push_back(32'h500);
      cycle();
      jump = 1'b0;
      wait_state(REQ);
      chk("overwrite_valid", inst_valid, 0);
      branch_taken = 1'b1; branch_target = 32'h600;
      exp_addr_q.push_back(32'h600);
      cycle();
      branch_taken = 1'b0;
      wait_state(REQ);
      p = 32'h600;
`ifdef FETCH_EXC_EN
      wait_state(WAIT);
      exc_req = 1'b1;
      jump = 1'b1; jump_target = 32'h700;
      exp_addr_q.push_back(EXC_VECTOR);
      cycle();
      exc_req = 1'b0;
      jump = 1'b0;
      wait_state(REQ);
      p = EXC_VECTOR;
`endif
      push_inst(p);
      exp_addr_q.push_back(p + 32'd4);
      wait_state(HOLD);
      wait_state(WAIT);
      RST = 1'b1;
      #1;
      chk("wait_rst_ce", inst_ce, 0);
      chk("wait_rst_valid", inst_valid, 0);
      chk("wait_rst_state", fsm_state, BOOT);
      chk("wait_rst_addr", inst_addr, 32'h0);
      repeat (3) cycle();
      chk("p3_addr_q_empty", exp_addr_q.size(), 0);
      chk("p3_inst_q_empty", exp_inst_q.size(), 0);
      chk("wrap_q_empty", exp_w_q.size(), 0);
      chk("wrap_inst_q_empty", exp_winst_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
